// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizes for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int REG_W = 16;
  localparam int NREG  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} arb_state_t;
  typedef enum logic {OWN_SEL_A, OWN_SEL_B} owner_t;

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: index mux with optional same-cycle write bypass.
module regfile_read_port #(
  parameter int NREG   = 8,
  parameter int W      = 16,
  parameter int BYPASS = 1
) (
  input  logic [NREG*W-1:0]         reg_q,
  input  logic [NREG-1:0]           reg_en,
  input  logic [W-1:0]              reg_din,
  input  logic [$clog2(NREG)-1:0]   sel,
  output logic [W-1:0]              dout
);

  always_comb begin
    dout = reg_q[sel*W +: W];
    if ((BYPASS != 0) && reg_en[sel]) dout = reg_din;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-path arbiter for the 8x16 register file, with bounded bursts and two read ports.
//   state | meaning
//   IDLE  | no owner; next request (tie -> not last_owner) takes the path
//   OWN_A | A owns the write path; granted every cycle it requests
//   OWN_B | B owns the write path; granted every cycle it requests
module regfile_write_arbiter #(
  parameter int NREG      = regfile_arb_pkg::NREG,
  parameter int W         = regfile_arb_pkg::REG_W,
  parameter int MAX_BURST = 4,
  parameter int BYPASS    = 1,
  localparam int SEL_W    = $clog2(NREG),
  localparam int CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              a_req,
  input  logic [SEL_W-1:0]  a_dr,
  input  logic [W-1:0]      a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [SEL_W-1:0]  b_dr,
  input  logic [W-1:0]      b_data,
  output logic              b_gnt,
  output logic [NREG-1:0]   reg_en,
  output logic [W-1:0]      reg_din,
  input  logic [NREG*W-1:0] reg_q,
  input  logic [SEL_W-1:0]  sr1_sel,
  input  logic [SEL_W-1:0]  sr2_sel,
  output logic [W-1:0]      sr1_out,
  output logic [W-1:0]      sr2_out
);
  import regfile_arb_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_nxt;
  owner_t           last_owner, last_owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             own_req, oth_req, own_gnt, burst_end;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= OWN_SEL_B;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    burst_cnt_nxt  = burst_cnt;
    last_owner_nxt = last_owner;
    a_gnt          = (state == OWN_A) && a_req && !Reset;
    b_gnt          = (state == OWN_B) && b_req && !Reset;
    own_req        = (state == OWN_A) ? a_req : b_req;
    oth_req        = (state == OWN_A) ? b_req : a_req;
    own_gnt        = a_gnt || b_gnt;
    // The burst ends on the grant that finds the counter already saturated.
    burst_end      = own_gnt && (burst_cnt == CNT_MAX);

    unique case (state)
      IDLE: begin
        if (a_req && (!b_req || (last_owner == OWN_SEL_B))) begin
          state_nxt      = OWN_A;
          burst_cnt_nxt  = '0;
          last_owner_nxt = OWN_SEL_A;
        end else if (b_req) begin
          state_nxt      = OWN_B;
          burst_cnt_nxt  = '0;
          last_owner_nxt = OWN_SEL_B;
        end
      end
      OWN_A, OWN_B: begin
        if (own_gnt && (burst_cnt != CNT_MAX)) burst_cnt_nxt = burst_cnt + 1'b1;
        if (oth_req && (!own_req || burst_end)) begin
          burst_cnt_nxt = '0;
          if (state == OWN_A) begin
            state_nxt      = OWN_B;
            last_owner_nxt = OWN_SEL_B;
          end else begin
            state_nxt      = OWN_A;
            last_owner_nxt = OWN_SEL_A;
          end
        end else if (!own_req) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    reg_en  = '0;
    reg_din = '0;
    if (a_gnt) begin
      reg_en[a_dr] = 1'b1;
      reg_din      = a_data;
    end else if (b_gnt) begin
      reg_en[b_dr] = 1'b1;
      reg_din      = b_data;
    end
  end

  regfile_read_port #(.NREG(NREG), .W(W), .BYPASS(BYPASS)) u_sr1 (
    .reg_q   (reg_q),
    .reg_en  (reg_en),
    .reg_din (reg_din),
    .sel     (sr1_sel),
    .dout    (sr1_out)
  );

  regfile_read_port #(.NREG(NREG), .W(W), .BYPASS(BYPASS)) u_sr2 (
    .reg_q   (reg_q),
    .reg_en  (reg_en),
    .reg_din (reg_din),
    .sel     (sr2_sel),
    .dout    (sr2_out)
  );

endmodule
